corescore_stream_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single byte-wide AXI-stream input of the UART emitter between N independent stream sources. Once it grants a source, it stays on that source until the source's tlast beat. A stalled source is cut off after a programmable idle timeout: the arbiter emits a terminating abort byte and discards the rest of that packet. The block sits between the core-side stream producers and the emitter, and its output is registered through a 2-entry skid buffer.

---
 rtl/corescore_stream_arbiter.sv | 159 +++++++++++++++
 tb/tb_corescore_stream_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/corescore_stream_arbiter.sv
// Packet-level round-robin arbiter merging N byte streams into one, with stall abort
// and a 2-entry registered skid buffer on the output.
module corescore_stream_arbiter #(
    parameter int unsigned N          = 4,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [7:0]  ABORT_BYTE = 8'h21
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [8*N-1:0] i_tdata,
    input  logic [N-1:0]   i_tlast,
    input  logic [N-1:0]   i_tvalid,
    output logic [N-1:0]   o_tready,
    output logic [7:0]     o_tdata,
    output logic           o_tlast,
    output logic           o_tvalid,
    input  logic           i_tready,
    output logic [N-1:0]   o_grant,
    output logic [7:0]     o_abort_cnt
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StPass, StAbort, StDiscard} state_e;

    state_e        state_q, state_d;
    // The pointer only moves on a grant, so it doubles as the current owner index.
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [7:0]    abort_cnt_q, abort_cnt_d;

    logic [7:0]    buf_data_q [2];
    logic [1:0]    buf_last_q;
    logic          wr_q, rd_q;
    logic [1:0]    cnt_q, cnt_d;
    logic          free_q;

    logic          push, pop, push_last;
    logic [7:0]    push_data;
    logic [IW-1:0] cand, next_idx;
    logic          any_req;

    // Descending scan so the smallest cyclic offset after the pointer wins.
    always_comb begin
        cand     = ptr_q;
        next_idx = ptr_q;
        any_req  = 1'b0;
        for (int unsigned i = N; i >= 1; i--) begin
            cand = IW'((32'(ptr_q) + i) % N);
            if (i_tvalid[cand]) begin
                next_idx = cand;
                any_req  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        stall_d     = stall_q;
        abort_cnt_d = abort_cnt_q;
        o_tready    = '0;
        push        = 1'b0;
        push_data   = i_tdata[8*ptr_q +: 8];
        push_last   = i_tlast[ptr_q];
        unique case (state_q)
            StIdle: begin
                stall_d = '0;
                if (any_req) begin
                    ptr_d   = next_idx;
                    state_d = StPass;
                end
            end
            StPass: begin
                o_tready[ptr_q] = free_q;
                if (i_tvalid[ptr_q] && free_q) begin
                    push    = 1'b1;
                    stall_d = '0;
                    if (i_tlast[ptr_q]) state_d = StIdle;
                end else if (!i_tvalid[ptr_q]) begin
                    stall_d = stall_q + 1'b1;
                    if (TIMEOUT != 0 && stall_d == CW'(TIMEOUT)) begin
                        state_d = StAbort;
                        stall_d = '0;
                        if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
                    end
                end
            end
            StAbort: begin
                push_data = ABORT_BYTE;
                push_last = 1'b1;
                if (free_q) begin
                    push    = 1'b1;
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                o_tready[ptr_q] = 1'b1;
                if (i_tvalid[ptr_q] && i_tlast[ptr_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= IW'(N - 1);
            stall_q     <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            stall_q     <= stall_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign o_tvalid = (cnt_q != 2'd0);
    assign pop      = o_tvalid && i_tready;
    assign o_tdata  = buf_data_q[rd_q];
    assign o_tlast  = buf_last_q[rd_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!push && pop) cnt_d = cnt_q - 2'd1;
    end

    // free_q is registered from cnt_d so o_tready never depends on i_tready combinationally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q    <= '0;
            wr_q          <= 1'b0;
            rd_q          <= 1'b0;
            cnt_q         <= '0;
            free_q        <= 1'b1;
        end else begin
            if (push) begin
                buf_data_q[wr_q] <= push_data;
                buf_last_q[wr_q] <= push_last;
                wr_q             <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q  <= cnt_d;
            free_q <= (cnt_d != 2'd2);
        end
    end

    always_comb begin
        o_grant = '0;
        if (state_q != StIdle) o_grant[ptr_q] = 1'b1;
    end

    assign o_abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Directed scoreboard bench for corescore_stream_arbiter (N=4, TIMEOUT=8).
module tb_corescore_stream_arbiter;
    localparam int unsigned NSRC = 4;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic [8*NSRC-1:0] i_tdata;
    logic [NSRC-1:0]   i_tlast;
    logic [NSRC-1:0]   i_tvalid;
    logic [NSRC-1:0]   o_tready;
    logic [7:0]        o_tdata;
    logic              o_tlast;
    logic              o_tvalid;
    logic              i_tready;
    logic [NSRC-1:0]   o_grant;
    logic [7:0]        o_abort_cnt;

    int checks = 0;
    int errors = 0;

    logic [8:0]      srcq [NSRC][$];
    logic [8:0]      sb[$];
    logic [NSRC-1:0] pend;
    int              acc_cnt [NSRC];

    bit gap_en = 1'b0;
    bit seen = 1'b0;
    bit prev_last = 1'b0;
    int gap = 0;

    always #5 clk = ~clk;

    corescore_stream_arbiter #(
        .N          (NSRC),
        .TIMEOUT    (8),
        .ABORT_BYTE (8'h21)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_tdata     (i_tdata),
        .i_tlast     (i_tlast),
        .i_tvalid    (i_tvalid),
        .o_tready    (o_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .i_tready    (i_tready),
        .o_grant     (o_grant),
        .o_abort_cnt (o_abort_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int src, input logic [7:0] base, input int len,
                        input bit last, input bit expect_out);
        logic [8:0] beat;
        for (int j = 0; j < len; j++) begin
            beat = {last && (j == len - 1), base + 8'(j)};
            srcq[src].push_back(beat);
            if (expect_out) sb.push_back(beat);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_grant();
        for (int c = 0; c < 20 && o_grant == '0; c++) cycles(1);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 400 && sb.size() != 0; c++) cycles(1);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    // Source models: a beat presented at one falling edge is consumed if the
    // rising edge that follows saw valid and ready together.
    initial begin
        logic [8:0] head;
        pend = '0;
        for (int k = 0; k < NSRC; k++) acc_cnt[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NSRC; k++) begin
                if (!i_rst_n) begin
                    pend[k] = 1'b0;
                end else if (pend[k]) begin
                    void'(srcq[k].pop_front());
                    acc_cnt[k]++;
                    pend[k] = 1'b0;
                end
                if (i_rst_n && srcq[k].size() != 0) begin
                    head            = srcq[k][0];
                    i_tvalid[k]     = 1'b1;
                    i_tdata[8*k+:8] = head[7:0];
                    i_tlast[k]      = head[8];
                end else begin
                    i_tvalid[k] = 1'b0;
                    i_tlast[k]  = 1'b0;
                end
                pend[k] = i_tvalid[k] & o_tready[k];
            end
        end
    end

    // Output monitor: every emitter handshake is matched against the scoreboard.
    initial begin
        logic [8:0] exp_beat;
        forever begin
            @(negedge clk);
            if (i_rst_n && o_tvalid && i_tready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 32'({o_tlast, o_tdata}), 32'hFFFF_FFFF);
                end else begin
                    exp_beat = sb.pop_front();
                    check("out_beat", 32'({o_tlast, o_tdata}), 32'(exp_beat));
                end
                if (gap_en) begin
                    if (seen) check("beat_gap", 32'(gap), prev_last ? 32'd1 : 32'd0);
                    seen      = 1'b1;
                    gap       = 0;
                    prev_last = o_tlast;
                end
            end else if (gap_en && seen) begin
                gap++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        i_rst_n  = 1'b1;
        i_tready = 1'b1;
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        #1 i_rst_n = 1'b0;
        #2;
        check("rst_tready", 32'(o_tready), 32'd0);
        check("rst_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_tdata", 32'(o_tdata), 32'd0);
        check("rst_tlast", 32'(o_tlast), 32'd0);
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_abort_cnt", 32'(o_abort_cnt), 32'd0);
        cycles(2);
        i_rst_n = 1'b1;
        cycles(1);

        // All four sources request: order 0,1,2,3,0 with one bubble between packets.
        gap_en = 1'b1;
        seen   = 1'b0;
        send(0, 8'h00, 3, 1'b1, 1'b1);
        send(1, 8'h10, 3, 1'b1, 1'b1);
        send(2, 8'h20, 3, 1'b1, 1'b1);
        send(3, 8'h30, 3, 1'b1, 1'b1);
        send(0, 8'h05, 3, 1'b1, 1'b1);
        drain("rr_drain");
        gap_en = 1'b0;
        cycles(2);

        // Lone source 2 packet.
        send(2, 8'h41, 3, 1'b1, 1'b1);
        wait_grant();
        check("grant_src2", 32'(o_grant), 32'h4);
        drain("src2_drain");
        cycles(2);

        // Backpressure from an empty buffer: exactly two accepts, then held output.
        i_tready = 1'b0;
        send(3, 8'h60, 5, 1'b1, 1'b1);
        a0 = acc_cnt[3];
        for (int c = 1; c <= 10; c++) begin
            cycles(1);
            if (c >= 4) check("bp_hold", 32'({o_tvalid, o_tdata}), 32'h160);
        end
        check("bp_accepts", 32'(acc_cnt[3] - a0), 32'd2);
        check("bp_tready", 32'(o_tready[3]), 32'd0);
        i_tready = 1'b1;
        drain("bp_drain");
        cycles(2);

        // Source 1 stalls mid-packet: abort byte, discard, then source 2 wins.
        send(1, 8'h30, 2, 1'b0, 1'b1);
        sb.push_back(9'h121);
        cycles(25);
        check("abort_cnt", 32'(o_abort_cnt), 32'd1);
        check("discard_tready", 32'(o_tready), 32'h2);
        check("discard_grant", 32'(o_grant), 32'h2);
        send(1, 8'h32, 3, 1'b1, 1'b0);
        send(2, 8'h70, 2, 1'b1, 1'b1);
        send(0, 8'h80, 2, 1'b1, 1'b1);
        drain("abort_drain");
        check("discard_consumed", 32'(srcq[1].size()), 32'd0);
        cycles(2);

        // Seven stall cycles then tlast: normal end, no abort.
        send(3, 8'h90, 1, 1'b0, 1'b1);
        a0 = acc_cnt[3];
        for (int c = 0; c < 50 && acc_cnt[3] == a0; c++) cycles(1);
        repeat (6) @(posedge clk);
        #2;
        send(3, 8'h91, 1, 1'b1, 1'b1);
        drain("stall7_drain");
        check("stall7_abort_cnt", 32'(o_abort_cnt), 32'd1);
        check("stall7_idle", 32'(o_grant), 32'd0);

        // Reset during a buffered packet.
        i_tready = 1'b0;
        send(3, 8'hA0, 4, 1'b1, 1'b0);
        cycles(6);
        check("pre_rst_tvalid", 32'(o_tvalid), 32'd1);
        i_rst_n = 1'b0;
        for (int k = 0; k < NSRC; k++) srcq[k].delete();
        sb.delete();
        pend     = '0;
        i_tvalid = '0;
        i_tlast  = '0;
        #1;
        check("mid_rst_tvalid", 32'(o_tvalid), 32'd0);
        check("mid_rst_grant", 32'(o_grant), 32'd0);
        check("mid_rst_tready", 32'(o_tready), 32'd0);
        check("mid_rst_abort_cnt", 32'(o_abort_cnt), 32'd0);
        i_tready = 1'b1;
        cycles(1);
        i_rst_n = 1'b1;
        cycles(1);
        send(2, 8'hB0, 2, 1'b1, 1'b0);
        send(0, 8'hC0, 2, 1'b1, 1'b1);
        send(2, 8'hB0, 2, 1'b1, 1'b1);
        srcq[2].delete();
        send(2, 8'hB0, 2, 1'b1, 1'b0);
        wait_grant();
        check("post_rst_grant", 32'(o_grant), 32'h1);
        drain("post_rst_drain");

        cycles(4);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
